// File: rtl/cipher_vault.sv
// Symbol-serial encrypt/decrypt vault with a circular (ciphertext, key) record table and decrypt lockout.
// Optional macro CIPHER_VAULT_LOCK_TIMEOUT_EN: LOCKED releases after LOCK_CYCLES instead of only on rst.
module cipher_vault #(
  parameter int N_SYM       = 10,
  parameter int SYM_W       = 8,
  parameter int MOD_BITS    = 6,
  parameter int KEY_W       = 8,
  parameter int DEPTH       = 10,
  parameter int MAX_TRIALS  = 3,
  parameter int SEED        = 5,
  parameter int LOCK_CYCLES = 300000000
) (
  input  logic                             msclk,
  input  logic                             rst,
  input  logic [KEY_W-1:0]                 key,
  input  logic [N_SYM*SYM_W-1:0]           data_in,
  input  logic                             enc_req,
  input  logic                             dec_req,
  output logic [N_SYM*SYM_W-1:0]           data_out,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             fail,
  output logic [$clog2(MAX_TRIALS+1)-1:0]  trials_left,
  output logic                             locked,
  output logic [$clog2(DEPTH+1)-1:0]       rec_count
);

  localparam int WORD_W  = N_SYM * SYM_W;
  localparam int ARITH_W = MOD_BITS + KEY_W + 1;
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SIDX_W  = (N_SYM > 1) ? $clog2(N_SYM) : 1;
  localparam int TR_W    = $clog2(MAX_TRIALS + 1);
  localparam int CNT_W   = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE, ENC, STORE, SEARCH, DEC, DONE, MISS, LOCKED
  } state_t;

  state_t              state;
  logic [WORD_W-1:0]   data_q;
  logic [WORD_W-1:0]   res_q;
  logic [KEY_W-1:0]    key_q;
  logic [MOD_BITS-1:0] prev_q;
  logic [SIDX_W-1:0]   sym_idx;
  logic [IDX_W-1:0]    tbl_idx;
  logic [IDX_W-1:0]    wptr;
  logic [DEPTH-1:0]    tbl_vld;
  logic [WORD_W-1:0]   tbl_data [DEPTH];
  logic [KEY_W-1:0]    tbl_key  [DEPTH];

  logic [SYM_W-1:0]    cur_sym;
  logic [ARITH_W-1:0]  enc_sum;
  logic [ARITH_W-1:0]  dec_diff;
  logic [SYM_W-1:0]    enc_sym;
  logic [SYM_W-1:0]    dec_sym;
  logic                hit;

  // Only the low MOD_BITS of the wide sums matter after reduction.
  logic unused_arith_hi;
  assign unused_arith_hi = ^{enc_sum[ARITH_W-1:MOD_BITS], dec_diff[ARITH_W-1:MOD_BITS]};

  always_comb begin
    cur_sym  = data_q[WORD_W-1 -: SYM_W];
    enc_sum  = ARITH_W'(prev_q) + ARITH_W'(key_q) + ARITH_W'(cur_sym[MOD_BITS-1:0]);
    dec_diff = ARITH_W'(cur_sym[MOD_BITS-1:0]) - ARITH_W'(prev_q) - ARITH_W'(key_q);
    enc_sym  = '0;
    dec_sym  = '0;
    if (cur_sym != '0) begin
      enc_sym = SYM_W'(enc_sum[MOD_BITS-1:0]);
      dec_sym = SYM_W'(dec_diff[MOD_BITS-1:0]);
    end
    hit = tbl_vld[tbl_idx] && (tbl_data[tbl_idx] == data_q) && (tbl_key[tbl_idx] == key_q);
  end

  // Table payload needs no reset; the valid bits alone define occupancy.
  always_ff @(posedge msclk) begin
    if (!rst && state == STORE) begin
      tbl_data[wptr] <= res_q;
      tbl_key[wptr]  <= key_q;
    end
  end

`ifdef CIPHER_VAULT_LOCK_TIMEOUT_EN
  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  logic [LOCK_W-1:0] lock_cnt;
`else
  logic unused_lock_cycles;
  assign unused_lock_cycles = ^LOCK_CYCLES;
`endif

  always_ff @(posedge msclk) begin
    if (rst) begin
      state       <= IDLE;
      data_out    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      fail        <= 1'b0;
      locked      <= 1'b0;
      trials_left <= TR_W'(MAX_TRIALS);
      rec_count   <= '0;
      tbl_vld     <= '0;
      wptr        <= '0;
      sym_idx     <= '0;
      tbl_idx     <= '0;
      prev_q      <= '0;
      data_q      <= '0;
      key_q       <= '0;
      res_q       <= '0;
`ifdef CIPHER_VAULT_LOCK_TIMEOUT_EN
      lock_cnt    <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      fail      <= 1'b0;
      case (state)
        IDLE: begin
          if (enc_req) begin
            data_q  <= data_in;
            key_q   <= key;
            prev_q  <= MOD_BITS'(SEED);
            sym_idx <= '0;
            busy    <= 1'b1;
            state   <= ENC;
          end else if (dec_req) begin
            data_q  <= data_in;
            key_q   <= key;
            prev_q  <= MOD_BITS'(SEED);
            tbl_idx <= '0;
            busy    <= 1'b1;
            state   <= SEARCH;
          end
        end
        ENC: begin
          res_q  <= (res_q << SYM_W) | WORD_W'(enc_sym);
          data_q <= data_q << SYM_W;
          if (cur_sym != '0) prev_q <= cur_sym[MOD_BITS-1:0];
          if (sym_idx == SIDX_W'(N_SYM-1)) state <= STORE;
          else sym_idx <= sym_idx + SIDX_W'(1);
        end
        STORE: begin
          tbl_vld[wptr] <= 1'b1;
          wptr <= (wptr == IDX_W'(DEPTH-1)) ? '0 : wptr + IDX_W'(1);
          if (rec_count < CNT_W'(DEPTH)) rec_count <= rec_count + CNT_W'(1);
          state <= DONE;
        end
        SEARCH: begin
          if (hit) begin
            sym_idx <= '0;
            state   <= DEC;
          end else if (tbl_idx == IDX_W'(DEPTH-1)) begin
            state <= MISS;
          end else begin
            tbl_idx <= tbl_idx + IDX_W'(1);
          end
        end
        DEC: begin
          res_q  <= (res_q << SYM_W) | WORD_W'(dec_sym);
          data_q <= data_q << SYM_W;
          if (cur_sym != '0) prev_q <= dec_sym[MOD_BITS-1:0];
          if (sym_idx == SIDX_W'(N_SYM-1)) begin
            trials_left <= TR_W'(MAX_TRIALS);
            state       <= DONE;
          end else begin
            sym_idx <= sym_idx + SIDX_W'(1);
          end
        end
        DONE: begin
          data_out  <= res_q;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        MISS: begin
          data_out    <= '0;
          fail        <= 1'b1;
          busy        <= 1'b0;
          trials_left <= trials_left - TR_W'(1);
          if (trials_left <= TR_W'(1)) begin
            locked <= 1'b1;
            state  <= LOCKED;
`ifdef CIPHER_VAULT_LOCK_TIMEOUT_EN
            lock_cnt <= LOCK_W'(LOCK_CYCLES-1);
`endif
          end else begin
            state <= IDLE;
          end
        end
        LOCKED: begin
`ifdef CIPHER_VAULT_LOCK_TIMEOUT_EN
          if (lock_cnt == '0) begin
            locked      <= 1'b0;
            trials_left <= TR_W'(MAX_TRIALS);
            state       <= IDLE;
          end else begin
            lock_cnt <= lock_cnt - LOCK_W'(1);
          end
`else
          state <= LOCKED;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_vault.sv
// Directed self-checking bench for cipher_vault (default parameters, key/data vectors worked by hand).
module tb_cipher_vault;

`ifdef CIPHER_VAULT_LOCK_TIMEOUT_EN
  localparam int LC = 20;
`else
  localparam int LC = 300000000;
`endif

  logic        msclk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  key = '0;
  logic [79:0] data_in = '0;
  logic        enc_req = 1'b0;
  logic        dec_req = 1'b0;
  logic [79:0] data_out;
  logic        out_valid, busy, fail, locked;
  logic [1:0]  trials_left;
  logic [3:0]  rec_count;

  int checks = 0;
  int failures = 0;

  localparam logic [79:0] PLAIN1 = 80'h3C57454C434F4D453C3B;
  localparam logic [79:0] CIPH1  = 80'h01131C110F121C120137;
  localparam logic [79:0] PMOD1  = 80'h3C17050C030F0D053C3B;

  cipher_vault #(.LOCK_CYCLES(LC)) dut (
    .msclk(msclk), .rst(rst), .key(key), .data_in(data_in),
    .enc_req(enc_req), .dec_req(dec_req), .data_out(data_out),
    .out_valid(out_valid), .busy(busy), .fail(fail),
    .trials_left(trials_left), .locked(locked), .rec_count(rec_count)
  );

  always #5 msclk = ~msclk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge msclk);
    #1 rst = 1'b0;
  endtask

  // Pulses a request for one cycle and observes 30 cycles; offsets count from the request cycle.
  task automatic run_op(input logic do_enc, input logic do_dec, input logic [7:0] k,
                        input logic [79:0] d, output int lat_v, output int lat_f,
                        output int n_v, output int n_f, output logic [79:0] got,
                        output logic busy1);
    @(posedge msclk); #1;
    enc_req = do_enc; dec_req = do_dec; key = k; data_in = d;
    @(posedge msclk); #1;
    enc_req = 1'b0; dec_req = 1'b0;
    lat_v = -1; lat_f = -1; n_v = 0; n_f = 0; got = '0; busy1 = busy;
    for (int n = 1; n <= 30; n++) begin
      if (out_valid) begin
        n_v++;
        if (lat_v < 0) begin lat_v = n; got = data_out; end
      end
      if (fail) begin
        n_f++;
        if (lat_f < 0) lat_f = n;
      end
      @(posedge msclk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge msclk);
    #1;
    checks++; if (data_out !== '0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
    checks++; if ({out_valid, fail, busy, locked} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {out_valid, fail, busy, locked}); end
    checks++; if (trials_left !== 2'd3) begin failures++; $display("FAIL reset_trials got=%0d exp=3", trials_left); end
    checks++; if (rec_count !== 4'd0) begin failures++; $display("FAIL reset_rec_count got=%0d exp=0", rec_count); end
    rst = 1'b0;
  endtask

  task automatic test_encrypt();
    int lv, lf, nv, nf; logic [79:0] got; logic b1;
    run_op(1'b1, 1'b0, 8'h00, PLAIN1, lv, lf, nv, nf, got, b1);
    checks++; if (lv !== 13) begin failures++; $display("FAIL enc_latency got=%0d exp=13", lv); end
    checks++; if (got !== CIPH1) begin failures++; $display("FAIL enc_data got=%h exp=%h", got, CIPH1); end
    checks++; if (nv !== 1 || nf !== 0) begin failures++; $display("FAIL enc_pulses got_valid=%0d got_fail=%0d exp=1/0", nv, nf); end
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL enc_busy got=%b exp=1", b1); end
    checks++; if (rec_count !== 4'd1) begin failures++; $display("FAIL enc_rec_count got=%0d exp=1", rec_count); end
  endtask

  task automatic test_decrypt_hit();
    int lv, lf, nv, nf; logic [79:0] got; logic b1;
    run_op(1'b0, 1'b1, 8'h00, CIPH1, lv, lf, nv, nf, got, b1);
    checks++; if (lv !== 13) begin failures++; $display("FAIL dec_latency got=%0d exp=13", lv); end
    checks++; if (got !== PMOD1) begin failures++; $display("FAIL dec_data got=%h exp=%h", got, PMOD1); end
    checks++; if (nf !== 0) begin failures++; $display("FAIL dec_no_fail got=%0d exp=0", nf); end
    checks++; if (trials_left !== 2'd3) begin failures++; $display("FAIL dec_trials got=%0d exp=3", trials_left); end
  endtask

  task automatic test_lockout();
    int lv, lf, nv, nf, n; logic [79:0] got; logic b1;
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, 1'b1, 8'h01, CIPH1, lv, lf, nv, nf, got, b1);
      checks++; if (lf !== 12) begin failures++; $display("FAIL miss_latency[%0d] got=%0d exp=12", i, lf); end
      checks++; if (nv !== 0) begin failures++; $display("FAIL miss_no_valid[%0d] got=%0d exp=0", i, nv); end
      checks++; if (data_out !== '0) begin failures++; $display("FAIL miss_data_out[%0d] got=%h exp=0", i, data_out); end
      checks++; if (trials_left !== 2'(2 - i)) begin failures++; $display("FAIL miss_trials[%0d] got=%0d exp=%0d", i, trials_left, 2 - i); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL miss_not_locked[%0d] got=%b exp=0", i, locked); end
    end
    @(posedge msclk); #1;
    dec_req = 1'b1; key = 8'h01; data_in = CIPH1;
    @(posedge msclk); #1;
    dec_req = 1'b0;
    n = 1;
    while (!fail && n < 40) begin @(posedge msclk); #1; n++; end
    checks++; if (n !== 12) begin failures++; $display("FAIL third_miss_latency got=%0d exp=12", n); end
    checks++; if (locked !== 1'b1 || trials_left !== 2'd0) begin failures++; $display("FAIL lock_entry got_locked=%b got_trials=%0d exp=1/0", locked, trials_left); end
`ifdef CIPHER_VAULT_LOCK_TIMEOUT_EN
    n = 0;
    while (locked && n < 100) begin @(posedge msclk); #1; n++; end
    checks++; if (n !== 20) begin failures++; $display("FAIL lock_timeout got=%0d exp=20", n); end
    checks++; if (trials_left !== 2'd3) begin failures++; $display("FAIL lock_timeout_trials got=%0d exp=3", trials_left); end
`else
    run_op(1'b0, 1'b1, 8'h00, CIPH1, lv, lf, nv, nf, got, b1);
    checks++; if (nf !== 0 || nv !== 0) begin failures++; $display("FAIL locked_dec_ignored got_fail=%0d got_valid=%0d exp=0/0", nf, nv); end
    run_op(1'b1, 1'b0, 8'h00, PLAIN1, lv, lf, nv, nf, got, b1);
    checks++; if (nv !== 0) begin failures++; $display("FAIL locked_enc_ignored got=%0d exp=0", nv); end
    checks++; if (locked !== 1'b1 || busy !== 1'b0 || rec_count !== 4'd1) begin failures++; $display("FAIL locked_state got_locked=%b got_busy=%b got_rec=%0d exp=1/0/1", locked, busy, rec_count); end
`endif
  endtask

  task automatic test_zero_word_priority();
    int lv, lf, nv, nf; logic [79:0] got; logic b1;
    do_reset();
    run_op(1'b1, 1'b1, 8'h07, 80'h41, lv, lf, nv, nf, got, b1);
    checks++; if (lv !== 13) begin failures++; $display("FAIL prio_latency got=%0d exp=13", lv); end
    checks++; if (got !== 80'h0D) begin failures++; $display("FAIL zero_word_data got=%h exp=%h", got, 80'h0D); end
    checks++; if (nv !== 1 || nf !== 0) begin failures++; $display("FAIL prio_pulses got_valid=%0d got_fail=%0d exp=1/0", nv, nf); end
    checks++; if (rec_count !== 4'd1) begin failures++; $display("FAIL prio_rec_count got=%0d exp=1", rec_count); end
  endtask

  task automatic test_reset_mid_enc();
    int nv;
    @(posedge msclk); #1;
    enc_req = 1'b1; key = 8'h00; data_in = PLAIN1;
    @(posedge msclk); #1;
    enc_req = 1'b0;
    repeat (3) @(posedge msclk);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_enc_busy got=%b exp=1", busy); end
    rst = 1'b1;
    @(posedge msclk); #1;
    rst = 1'b0;
    checks++; if (data_out !== '0 || {out_valid, fail, busy, locked} !== 4'b0000) begin failures++; $display("FAIL abort_outputs got_data=%h got_flags=%b exp=0/0000", data_out, {out_valid, fail, busy, locked}); end
    checks++; if (rec_count !== 4'd0 || trials_left !== 2'd3) begin failures++; $display("FAIL abort_counts got_rec=%0d got_trials=%0d exp=0/3", rec_count, trials_left); end
    nv = 0;
    for (int n = 0; n < 20; n++) begin
      if (out_valid) nv++;
      @(posedge msclk); #1;
    end
    checks++; if (nv !== 0 || rec_count !== 4'd0) begin failures++; $display("FAIL abort_no_completion got_valid=%0d got_rec=%0d exp=0/0", nv, rec_count); end
  endtask

  task automatic test_wrap();
    int lv, lf, nv, nf; logic [79:0] got; logic b1;
    for (int i = 1; i <= 11; i++) begin
      run_op(1'b1, 1'b0, 8'h00, 80'(i), lv, lf, nv, nf, got, b1);
      checks++; if (got !== 80'((5 + i) % 64) || lv !== 13) begin failures++; $display("FAIL wrap_enc[%0d] got=%h lat=%0d exp=%h lat=13", i, got, lv, 80'((5 + i) % 64)); end
    end
    checks++; if (rec_count !== 4'd10) begin failures++; $display("FAIL wrap_rec_count got=%0d exp=10", rec_count); end
    run_op(1'b0, 1'b1, 8'h00, 80'h06, lv, lf, nv, nf, got, b1);
    checks++; if (lf !== 12 || nv !== 0) begin failures++; $display("FAIL overwritten_miss got_fail_lat=%0d got_valid=%0d exp=12/0", lf, nv); end
    checks++; if (trials_left !== 2'd2) begin failures++; $display("FAIL overwritten_trials got=%0d exp=2", trials_left); end
    run_op(1'b0, 1'b1, 8'h00, 80'h10, lv, lf, nv, nf, got, b1);
    checks++; if (lv !== 13 || nf !== 0) begin failures++; $display("FAIL newest_hit got_lat=%0d got_fail=%0d exp=13/0", lv, nf); end
    checks++; if (got !== 80'h0B) begin failures++; $display("FAIL newest_data got=%h exp=%h", got, 80'h0B); end
    checks++; if (trials_left !== 2'd3) begin failures++; $display("FAIL newest_trials got=%0d exp=3", trials_left); end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt_hit();
    test_lockout();
    test_zero_word_priority();
    test_reset_mid_enc();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
